// File: rtl/network_bf_out_pkg.sv
`default_nettype none
// ============================================================================
// Module   : network_bf_out_pkg
// Brief    : Shared bank-select codes and helpers for the NTT butterfly
//            input/output routing networks.
// Revision : 1.0
// ============================================================================
package network_bf_out_pkg;

  // Bank word -> butterfly port codes, shared with the input network.
  localparam logic [1:0] SEL_U0 = 2'b00;  // u0 on read, x0 on write-back
  localparam logic [1:0] SEL_V0 = 2'b01;  // v0 on read, y0 on write-back
  localparam logic [1:0] SEL_U1 = 2'b10;  // u1 on read, x1 on write-back
  localparam logic [1:0] SEL_V1 = 2'b11;  // v1 on read, y1 on write-back

  localparam int NUM_BANKS = 4;
  localparam int SEL_WIDTH = 2;
  localparam int SELS_W    = NUM_BANKS * SEL_WIDTH;

  // True when the four packed select codes {sel3,sel2,sel1,sel0} use every
  // code exactly once. With four banks and four codes, "all codes seen" is
  // equivalent to "no duplicates".
  function automatic logic sels_are_perm(input logic [SELS_W-1:0] sels);
    logic [NUM_BANKS-1:0] seen;
    seen = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      seen[sels[k*SEL_WIDTH +: SEL_WIDTH]] = 1'b1;
    end
    return &seen;
  endfunction

endpackage : network_bf_out_pkg
`default_nettype wire

// File: rtl/network_bf_out_pipe_delay.sv
`default_nettype none
// ============================================================================
// Module   : pipe_delay
// Brief    : Fixed-depth shift register with synchronous active-low reset.
//            The MSB of the word is treated as a valid flag; any_msb reports
//            whether any slot currently holds a valid entry.
// Revision : 1.0
// ============================================================================
module pipe_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             any_msb
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  // Shift one slot per cycle; reset empties every slot so nothing in flight survives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_sr[i] <= '0;
      end
    end else begin
      r_sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign q = r_sr[DEPTH-1];

  // OR of the valid flags across the whole line, used for the busy indication.
  always_comb begin
    any_msb = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_msb = any_msb | r_sr[i][WIDTH-1];
    end
  end

endmodule : pipe_delay
`default_nettype wire

// File: rtl/network_bf_out.sv
`default_nettype none
// ============================================================================
// Module   : network_bf_out
// Brief    : Write-back routing stage after the two radix-2 butterflies.
//            Delays each read issue's select codes and addresses to line up
//            with the butterfly results, routes x0/y0/x1/y1 back to the four
//            banks, counts writes per stage and flags illegal routings.
// Revision : 1.0
// ============================================================================
module network_bf_out
  import network_bf_out_pkg::*;
#(
  parameter int DATA_WIDTH       = 14,
  parameter int ADDR_WIDTH       = 6,
  parameter int BF_LATENCY       = 4,
  parameter int ISSUES_PER_STAGE = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [1:0]            sel_a_0,
  input  logic [1:0]            sel_a_1,
  input  logic [1:0]            sel_a_2,
  input  logic [1:0]            sel_a_3,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [ADDR_WIDTH-1:0] addr_2,
  input  logic [ADDR_WIDTH-1:0] addr_3,
  input  logic [DATA_WIDTH-1:0] x0,
  input  logic [DATA_WIDTH-1:0] y0,
  input  logic [DATA_WIDTH-1:0] x1,
  input  logic [DATA_WIDTH-1:0] y1,
  output logic [DATA_WIDTH-1:0] d0,
  output logic [DATA_WIDTH-1:0] d1,
  output logic [DATA_WIDTH-1:0] d2,
  output logic [DATA_WIDTH-1:0] d3,
  output logic [ADDR_WIDTH-1:0] wa0,
  output logic [ADDR_WIDTH-1:0] wa1,
  output logic [ADDR_WIDTH-1:0] wa2,
  output logic [ADDR_WIDTH-1:0] wa3,
  output logic                  wen0,
  output logic                  wen1,
  output logic                  wen2,
  output logic                  wen3,
  output logic                  stage_done,
  output logic                  busy,
  output logic                  route_err
);

  localparam int ADDRS_W = NUM_BANKS * ADDR_WIDTH;
  localparam int DATAS_W = NUM_BANKS * DATA_WIDTH;
  // Slot layout, MSB first: {valid, sel3..sel0, addr3..addr0}
  localparam int SLOT_W  = 1 + SELS_W + ADDRS_W;
  localparam int CNT_W   = (ISSUES_PER_STAGE > 1) ? $clog2(ISSUES_PER_STAGE) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(ISSUES_PER_STAGE - 1);

  logic [SLOT_W-1:0]  w_slot_in;
  logic [SLOT_W-1:0]  w_tap;
  logic               w_line_busy;
  logic               w_tap_valid;
  logic [SELS_W-1:0]  w_tap_sels;
  logic [ADDRS_W-1:0] w_tap_addrs;
  logic [DATAS_W-1:0] w_route_d;
  logic               w_last_write;

  logic [DATAS_W-1:0] r_d;
  logic [ADDRS_W-1:0] r_wa;
  logic               r_wen;
  logic               r_stage_done;
  logic               r_route_err;
  logic [CNT_W-1:0]   r_count;

  assign w_slot_in = {in_valid,
                      sel_a_3, sel_a_2, sel_a_1, sel_a_0,
                      addr_3, addr_2, addr_1, addr_0};

  // Latency-matching delay line: the issue reaches the tap together with x/y.
  pipe_delay #(
    .WIDTH (SLOT_W),
    .DEPTH (BF_LATENCY)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .d       (w_slot_in),
    .q       (w_tap),
    .any_msb (w_line_busy)
  );

  assign w_tap_valid = w_tap[SLOT_W-1];
  assign w_tap_sels  = w_tap[SLOT_W-2 -: SELS_W];
  assign w_tap_addrs = w_tap[ADDRS_W-1:0];

  // Inverse of the input network: each bank takes the port its select code named.
  always_comb begin
    w_route_d = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      case (w_tap_sels[k*SEL_WIDTH +: SEL_WIDTH])
        SEL_U0:  w_route_d[k*DATA_WIDTH +: DATA_WIDTH] = x0;
        SEL_V0:  w_route_d[k*DATA_WIDTH +: DATA_WIDTH] = y0;
        SEL_U1:  w_route_d[k*DATA_WIDTH +: DATA_WIDTH] = x1;
        SEL_V1:  w_route_d[k*DATA_WIDTH +: DATA_WIDTH] = y1;
        default: w_route_d[k*DATA_WIDTH +: DATA_WIDTH] = x0;
      endcase
    end
  end

  assign w_last_write = w_tap_valid && (r_count == C_CNT_LAST);

  // Write data/address registers: load on a valid tap, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_d  <= '0;
      r_wa <= '0;
    end else if (w_tap_valid) begin
      r_d  <= w_route_d;
      r_wa <= w_tap_addrs;
    end
  end

  // Write enable, stage counter and end-of-stage pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wen        <= 1'b0;
      r_stage_done <= 1'b0;
      r_count      <= '0;
    end else begin
      r_wen        <= w_tap_valid;
      r_stage_done <= w_last_write;
      if (w_last_write) begin
        r_count <= '0;
      end else if (w_tap_valid) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Sticky routing error: a valid slot whose selects are not a permutation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_route_err <= 1'b0;
    end else if (w_tap_valid && !sels_are_perm(w_tap_sels)) begin
      r_route_err <= 1'b1;
    end
  end

  assign d0  = r_d[0*DATA_WIDTH +: DATA_WIDTH];
  assign d1  = r_d[1*DATA_WIDTH +: DATA_WIDTH];
  assign d2  = r_d[2*DATA_WIDTH +: DATA_WIDTH];
  assign d3  = r_d[3*DATA_WIDTH +: DATA_WIDTH];
  assign wa0 = r_wa[0*ADDR_WIDTH +: ADDR_WIDTH];
  assign wa1 = r_wa[1*ADDR_WIDTH +: ADDR_WIDTH];
  assign wa2 = r_wa[2*ADDR_WIDTH +: ADDR_WIDTH];
  assign wa3 = r_wa[3*ADDR_WIDTH +: ADDR_WIDTH];

  assign wen0 = r_wen;
  assign wen1 = r_wen;
  assign wen2 = r_wen;
  assign wen3 = r_wen;

  assign stage_done = r_stage_done;
  assign route_err  = r_route_err;
  assign busy       = w_line_busy | r_wen;

endmodule : network_bf_out
`default_nettype wire

// File: tb/tb_network_bf_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_network_bf_out
// Brief    : Directed scoreboard testbench for network_bf_out.
// Revision : 1.0
// ============================================================================
module tb_network_bf_out;

  localparam int DW = 14;
  localparam int AW = 6;
  localparam int L  = 4;
  localparam int N  = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [1:0] sel_a_0 = '0, sel_a_1 = '0, sel_a_2 = '0, sel_a_3 = '0;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0, addr_2 = '0, addr_3 = '0;
  logic [DW-1:0] x0, y0, x1, y1;
  logic [DW-1:0] d0, d1, d2, d3;
  logic [AW-1:0] wa0, wa1, wa2, wa3;
  logic wen0, wen1, wen2, wen3;
  logic stage_done, busy, route_err;

  network_bf_out #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BF_LATENCY(L), .ISSUES_PER_STAGE(N)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .sel_a_0(sel_a_0), .sel_a_1(sel_a_1), .sel_a_2(sel_a_2), .sel_a_3(sel_a_3),
    .addr_0(addr_0), .addr_1(addr_1), .addr_2(addr_2), .addr_3(addr_3),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .wa0(wa0), .wa1(wa1), .wa2(wa2), .wa3(wa3),
    .wen0(wen0), .wen1(wen1), .wen2(wen2), .wen3(wen3),
    .stage_done(stage_done), .busy(busy), .route_err(route_err)
  );

  always #5 clk = ~clk;

  // Butterfly stand-in: data given with an issue appears L cycles later.
  logic [4*DW-1:0] n_data = '0;  // {x0,y0,x1,y1}
  logic [4*DW-1:0] dpipe [L];
  always @(posedge clk) begin
    dpipe[0] <= n_data;
    for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
  end
  assign {x0, y0, x1, y1} = dpipe[L-1];

  typedef struct {
    logic [4*DW-1:0] d;     // {d3,d2,d1,d0}
    logic [4*AW-1:0] wa;    // {wa3,wa2,wa1,wa0}
    logic            done;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_count = 0;
  logic m_err = 1'b0;
  logic [4*DW-1:0] last_d = '0;
  logic [4*AW-1:0] last_wa = '0;

  logic [4*DW-1:0] obs_d;
  logic [4*AW-1:0] obs_wa;
  logic [3:0]      obs_wen;
  assign obs_d   = {d3, d2, d1, d0};
  assign obs_wa  = {wa3, wa2, wa1, wa0};
  assign obs_wen = {wen3, wen2, wen1, wen0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bank k gets x0/y0/x1/y1 for select code 0/1/2/3.
  function automatic logic [4*DW-1:0] route(input logic [7:0] sels, input logic [4*DW-1:0] data);
    logic [4*DW-1:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      case (sels[2*k +: 2])
        2'd0: r[k*DW +: DW] = data[4*DW-1 -: DW];
        2'd1: r[k*DW +: DW] = data[3*DW-1 -: DW];
        2'd2: r[k*DW +: DW] = data[2*DW-1 -: DW];
        default: r[k*DW +: DW] = data[DW-1:0];
      endcase
    end
    return r;
  endfunction

  function automatic logic legal(input logic [7:0] sels);
    int cnt [4];
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int k = 0; k < 4; k++) cnt[sels[2*k +: 2]]++;
    return (cnt[0] == 1) && (cnt[1] == 1) && (cnt[2] == 1) && (cnt[3] == 1);
  endfunction

  function automatic logic [4*DW-1:0] rnd_data();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[4*DW-1:0];
  endfunction

  // Output checker: every wen cycle pops one expected write; gaps must hold.
  always @(negedge clk) begin
    if (rst) begin
      if (wen0) begin
        chk("wen_expected", 64'(exp_q.size() > 0), 64'(1));
        chk("wen_all", 64'(obs_wen), 64'(4'hf));
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_data", 64'(obs_d), 64'(e.d));
          chk("wr_addr", 64'(obs_wa), 64'(e.wa));
          chk("stage_done", 64'(stage_done), 64'(e.done));
          chk("route_err", 64'(route_err), 64'(e.err));
          last_d  = e.d;
          last_wa = e.wa;
        end
      end else begin
        chk("wen_idle", 64'(obs_wen), 64'(0));
        chk("hold_data", 64'(obs_d), 64'(last_d));
        chk("hold_addr", 64'(obs_wa), 64'(last_wa));
        chk("done_idle", 64'(stage_done), 64'(0));
      end
    end
  end

  task automatic issue(input logic [7:0] sels, input logic [4*AW-1:0] addrs,
                       input logic [4*DW-1:0] data);
    exp_t e;
    in_valid = 1'b1;
    {sel_a_3, sel_a_2, sel_a_1, sel_a_0} = sels;
    {addr_3, addr_2, addr_1, addr_0} = addrs;
    n_data = data;
    e.done = (m_count == N - 1);
    m_count = e.done ? 0 : m_count + 1;
    if (!legal(sels)) m_err = 1'b1;
    e.err = m_err;
    e.d = route(sels, data);
    e.wa = addrs;
    exp_q.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      {sel_a_3, sel_a_2, sel_a_1, sel_a_0} = 8'($urandom());
      {addr_3, addr_2, addr_1, addr_0} = 24'($urandom());
      n_data = rnd_data();
      @(negedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_err = 1'b0;
    last_d = '0;
    last_wa = '0;
    @(negedge clk); #1;
    rst = 1'b1;
  endtask

  // Wait (bounded) for all expected writes, then busy must be low next cycle.
  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
    @(negedge clk); #1;
    chk("busy_idle", 64'(busy), 64'(0));
  endtask

  function automatic logic [7:0] rot_sels(input int r);
    logic [7:0] s;
    for (int k = 0; k < 4; k++) s[2*k +: 2] = 2'((k + r) % 4);
    return s;
  endfunction

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_d", 64'(obs_d), 64'(0));
    chk("rst_wa", 64'(obs_wa), 64'(0));
    chk("rst_wen", 64'(obs_wen), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(stage_done), 64'(0));
    chk("rst_err", 64'(route_err), 64'(0));
    rst = 1'b1;
    idle(2);

    // 1: identity routing, exact latency bf_latency+1
    issue(8'b11_10_01_00, {6'd8, 6'd7, 6'd6, 6'd5}, {14'd100, 14'd200, 14'd300, 14'd400});
    chk("busy_inflight", 64'(busy), 64'(1));
    idle(3);
    chk("t1_no_early_wen", 64'(wen0), 64'(0));
    idle(1);
    chk("t1_wen", 64'(wen0), 64'(1));
    chk("t1_d", 64'(obs_d), 64'({14'd400, 14'd300, 14'd200, 14'd100}));
    chk("t1_wa", 64'(obs_wa), 64'({6'd8, 6'd7, 6'd6, 6'd5}));
    drain();

    // 2: reversed routing
    issue(8'b00_01_10_11, {6'd8, 6'd7, 6'd6, 6'd5}, {14'd100, 14'd200, 14'd300, 14'd400});
    idle(L);
    chk("t2_d", 64'(obs_d), 64'({14'd100, 14'd200, 14'd300, 14'd400}));
    drain();
    chk("t2_no_err", 64'(route_err), 64'(0));

    // 3: a full stage back-to-back
    do_reset();
    for (int i = 0; i < N; i++) issue(rot_sels(i % 4), 24'($urandom()), rnd_data());
    drain();

    // 4: duplicate selects, then legal traffic keeps route_err sticky
    issue(8'b11_10_00_00, {6'd1, 6'd2, 6'd3, 6'd4}, rnd_data());
    for (int i = 0; i < 3; i++) issue(rot_sels(i), 24'($urandom()), rnd_data());
    drain();
    chk("t4_err_sticky", 64'(route_err), 64'(1));
    do_reset();
    chk("t4_err_cleared", 64'(route_err), 64'(0));

    // 5: reset while an issue is in flight
    idle(2);
    issue(rot_sels(1), 24'h123456, rnd_data());
    idle(1);
    do_reset();
    chk("t5_d", 64'(obs_d), 64'(0));
    chk("t5_wa", 64'(obs_wa), 64'(0));
    chk("t5_wen", 64'(obs_wen), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    idle(L + 4);
    chk("t5_no_write", 64'(exp_q.size()), 64'(0));

    // 6: bubbles reproduce on wen, outputs hold during gaps
    issue(rot_sels(2), 24'($urandom()), rnd_data());
    idle(1);
    issue(rot_sels(3), 24'($urandom()), rnd_data());
    issue(rot_sels(0), 24'($urandom()), rnd_data());
    idle(1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_network_bf_out
`default_nettype wire
